// File: rtl/draw_cmd_pkg.sv
// draw_cmd_pkg: command codes, sprite colour encodings and FSM states shared by the draw sequencer.
package draw_cmd_pkg;

    localparam logic [4:0] CMD_SLOT_BASE = 5'b00001;
    localparam logic [4:0] CMD_DIGIT1    = 5'b10001;
    localparam logic [4:0] CMD_DIGIT2    = 5'b10010;
    localparam logic [4:0] CMD_ERASE     = 5'b10100;
    localparam logic [4:0] CMD_COMMIT    = 5'b10101;
    localparam logic [4:0] CMD_NOP       = 5'b10110;
    localparam logic [4:0] CMD_BAR_L     = 5'b10111;
    localparam logic [4:0] CMD_BAR_R     = 5'b11000;
    localparam logic [4:0] CMD_BAR_M     = 5'b11001;

    localparam logic [2:0] COL_PLAIN      = 3'b000;
    localparam logic [2:0] COL_RED_SMALL  = 3'b001;
    localparam logic [2:0] COL_BLUE_SMALL = 3'b010;
    localparam logic [2:0] COL_RED_BIG    = 3'b011;
    localparam logic [2:0] COL_BLUE_BIG   = 3'b100;

    typedef enum logic [1:0] {
        SPR_PLAIN,
        SPR_SMALL,
        SPR_BIG
    } sprite_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ERASE,
        ST_SLOT,
        ST_DIGIT1,
        ST_DIGIT2,
        ST_BAR_L,
        ST_BAR_R,
        ST_BAR_M,
        ST_COMMIT
    } state_t;

    // Any colour with the top bit set is a blue big face.
    function automatic sprite_t sprite_of(input logic [2:0] col);
        return ((col & COL_BLUE_BIG) != 3'b000 || col == COL_RED_BIG) ? SPR_BIG
             : (col == COL_RED_SMALL || col == COL_BLUE_SMALL)        ? SPR_SMALL
             : (col == COL_PLAIN)                                     ? SPR_PLAIN
             :                                                          SPR_BIG;
    endfunction

endpackage

// File: rtl/draw_sequencer_hold_timer.sv
// hold_timer: loadable 12-bit down-counter that stops at zero and flags it.
module hold_timer (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_load,
    input  logic [11:0] i_value,
    output logic        o_zero
);
    logic [11:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_value;
        end else if (r_cnt != 12'd0) begin
            r_cnt <= r_cnt - 12'd1;
        end
    end

    assign o_zero = (r_cnt == 12'd0);

endmodule

// File: rtl/draw_sequencer.sv
// draw_sequencer: issues the per-frame draw command stream, holding each command for its sprite's plot time.
module draw_sequencer
    import draw_cmd_pkg::*;
#(
    parameter int ERASE_CYCLES   = 2268,
    parameter int PLAIN_CYCLES   = 16,
    parameter int SMALL_CYCLES   = 81,
    parameter int BIG_CYCLES     = 169,
    parameter int DIGIT_CYCLES   = 1,
    parameter int MID_BAR_CYCLES = 32
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic [14:0] slot_valid,
    input  logic [44:0] slot_colour,
    output logic [4:0]  command,
    output logic        busy,
    output logic        frame_done,
    output logic        overrun
);
    state_t           r_state, w_next;
    logic [3:0]       r_slot, w_slot_next, w_nidx;
    logic [14:0]      r_valid;
    logic [14:0][2:0] r_col;
    logic [4:0]       r_cmd, w_cmd, w_ncmd;
    logic             r_busy, r_done, r_overrun;
    logic             w_load, w_zero, w_nv;
    logic [11:0]      w_val, w_nhold;
    sprite_t          w_spr;

    hold_timer u_hold (
        .i_clk   (CLK),
        .i_rst_n (reset),
        .i_load  (w_load),
        .i_value (w_val),
        .o_zero  (w_zero)
    );

    // Zero-based index of the slot entered next (slot 1 when leaving ERASE).
    assign w_nidx  = (r_state == ST_ERASE) ? 4'd0 : r_slot;
    assign w_nv    = r_valid[w_nidx];
    assign w_spr   = sprite_of(r_col[w_nidx]);
    assign w_nhold = !w_nv                  ? 12'd0
                   : (w_nidx >= 4'd10)      ? 12'(PLAIN_CYCLES - 1)
                   : (w_spr == SPR_BIG)     ? 12'(BIG_CYCLES - 1)
                   : (w_spr == SPR_SMALL)   ? 12'(SMALL_CYCLES - 1)
                   :                          12'(PLAIN_CYCLES - 1);
    assign w_ncmd  = w_nv ? CMD_SLOT_BASE + 5'(w_nidx) + 5'd1 : CMD_NOP;

    always_comb begin
        w_next      = r_state;
        w_slot_next = r_slot;
        w_cmd       = r_cmd;
        w_load      = 1'b0;
        w_val       = '0;
        case (r_state)
            ST_IDLE: if (frame_tick) begin
                w_next = ST_ERASE;
                w_cmd  = CMD_ERASE;
                w_load = 1'b1;
                w_val  = 12'(ERASE_CYCLES - 1);
            end
            ST_ERASE, ST_SLOT: if (w_zero) begin
                w_load = 1'b1;
                if (r_state == ST_SLOT && r_slot == 4'd15) begin
                    w_next      = ST_DIGIT1;
                    w_slot_next = 4'd1;
                    w_cmd       = CMD_DIGIT1;
                    w_val       = 12'(DIGIT_CYCLES - 1);
                end else begin
                    w_next      = ST_SLOT;
                    w_slot_next = w_nidx + 4'd1;
                    w_cmd       = w_ncmd;
                    w_val       = w_nhold;
                end
            end
            ST_DIGIT1: if (w_zero) begin
                w_next = ST_DIGIT2;
                w_cmd  = CMD_DIGIT2;
                w_load = 1'b1;
                w_val  = 12'(DIGIT_CYCLES - 1);
            end
            ST_DIGIT2: if (w_zero) begin
                w_next = ST_BAR_L;
                w_cmd  = CMD_BAR_L;
                w_load = 1'b1;
                w_val  = 12'(PLAIN_CYCLES - 1);
            end
            ST_BAR_L: if (w_zero) begin
                w_next = ST_BAR_R;
                w_cmd  = CMD_BAR_R;
                w_load = 1'b1;
                w_val  = 12'(PLAIN_CYCLES - 1);
            end
            ST_BAR_R: if (w_zero) begin
                w_next = ST_BAR_M;
                w_cmd  = CMD_BAR_M;
                w_load = 1'b1;
                w_val  = 12'(MID_BAR_CYCLES - 1);
            end
            ST_BAR_M: if (w_zero) begin
                w_next = ST_COMMIT;
                w_cmd  = CMD_COMMIT;
                w_load = 1'b1;
                w_val  = 12'd0;
            end
            default: begin
                w_next = ST_IDLE;
                w_cmd  = CMD_NOP;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the command.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_slot    <= 4'd1;
            r_valid   <= '0;
            r_col     <= '0;
            r_cmd     <= CMD_NOP;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_slot    <= w_slot_next;
            r_cmd     <= w_cmd;
            r_busy    <= (w_next != ST_IDLE);
            r_done    <= (w_next == ST_COMMIT);
            r_overrun <= frame_tick && (r_state != ST_IDLE);
            if (r_state == ST_IDLE && frame_tick) begin
                r_valid <= slot_valid;
                r_col   <= slot_colour;
            end
        end
    end

    assign command    = r_cmd;
    assign busy       = r_busy;
    assign frame_done = r_done;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_draw_sequencer.sv
// tb_draw_sequencer: directed table of frames plus hand sequences for reset, overrun and back-to-back ticks.
module tb_draw_sequencer;
    localparam logic [4:0] NOP   = 5'b10110;
    localparam logic [4:0] ERASE = 5'b10100;

    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic        frame_tick = 1'b0;
    logic [14:0] slot_valid = '0;
    logic [44:0] slot_colour = '0;
    logic [4:0]  command;
    logic        busy, frame_done, overrun;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [14:0] sv;
        logic [44:0] sc;
        int          busy;
    } vec_t;
    vec_t vecs [5];

    always #10 CLK = ~CLK;

    draw_sequencer dut (
        .CLK         (CLK),
        .reset       (reset),
        .frame_tick  (frame_tick),
        .slot_valid  (slot_valid),
        .slot_colour (slot_colour),
        .command     (command),
        .busy        (busy),
        .frame_done  (frame_done),
        .overrun     (overrun)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic run_frame(input logic [14:0] sv, input logic [44:0] sc, input int exp_busy,
                             input bit scramble, input bit inject, input string nm);
        int ec [22];
        int el [22];
        int mc [$];
        int ml [$];
        int qc [$];
        int ql [$];
        int nb = 0, nd = 0, no = 0;
        bit last_done = 0, pend = 0, hit5 = 0;
        logic [2:0] col;
        ec[0] = 5'b10100; el[0] = 2268;
        for (int i = 1; i <= 15; i++) begin
            col   = sc[3*i-3 +: 3];
            ec[i] = sv[i-1] ? i + 1 : 5'b10110;
            el[i] = !sv[i-1] ? 1 : (i > 10 || col == 3'b000) ? 16
                  : (col == 3'b001 || col == 3'b010) ? 81 : 169;
        end
        ec[16] = 5'b10001; el[16] = 1;
        ec[17] = 5'b10010; el[17] = 1;
        ec[18] = 5'b10111; el[18] = 16;
        ec[19] = 5'b11000; el[19] = 16;
        ec[20] = 5'b11001; el[20] = 32;
        ec[21] = 5'b10101; el[21] = 1;
        for (int i = 0; i < 22; i++) begin
            if (mc.size() > 0 && mc[mc.size()-1] == ec[i]) ml[ml.size()-1] += el[i];
            else begin
                mc.push_back(ec[i]);
                ml.push_back(el[i]);
            end
        end
        @(negedge CLK);
        slot_valid  = sv;
        slot_colour = sc;
        frame_tick  = 1'b1;
        @(negedge CLK);
        frame_tick = 1'b0;
        for (int c = 0; c < 6000; c++) begin
            if (pend) begin
                frame_tick = 1'b0;
                pend = 0;
                chk({nm, " overrun pulse"}, overrun, 1);
            end
            no += int'(overrun);
            if (!busy) break;
            nb++;
            nd += int'(frame_done);
            last_done = frame_done;
            if (qc.size() > 0 && qc[qc.size()-1] == int'(command)) ql[ql.size()-1]++;
            else begin
                qc.push_back(int'(command));
                ql.push_back(1);
            end
            if (scramble && c == 1) begin
                slot_valid  = ~sv;
                slot_colour = ~sc;
            end
            if (inject && ((command == 5'b00110 && !hit5) || command == 5'b10101)) begin
                frame_tick = 1'b1;
                pend = 1;
                hit5 = 1;
            end
            @(negedge CLK);
        end
        chk({nm, " timeout"}, busy, 0);
        chk({nm, " busy cycles"}, nb, exp_busy);
        chk({nm, " frame_done count"}, nd, 1);
        chk({nm, " frame_done at last busy"}, last_done, 1);
        chk({nm, " overrun count"}, no, inject ? 2 : 0);
        chk({nm, " idle command"}, command, NOP);
        chk({nm, " segment count"}, qc.size(), mc.size());
        for (int i = 0; i < mc.size() && i < qc.size(); i++) begin
            chk($sformatf("%s seg%0d cmd", nm, i), qc[i], mc[i]);
            chk($sformatf("%s seg%0d len", nm, i), ql[i], ml[i]);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad_b, bad_o, bad_d;
        vecs[0] = '{sv: 15'h0000, sc: 45'd0, busy: 2350};
        vecs[1] = '{sv: 15'h0403, sc: (45'd3 << 30) | (45'd3 << 3) | 45'd1, busy: 2613};
        vecs[2] = '{sv: 15'h7FFF, sc: 45'd0, busy: 2575};
        vecs[3] = '{sv: 15'h7FFF, sc: {45{1'b1}}, busy: 4105};
        vecs[4] = '{sv: 15'h4200, sc: (45'd4 << 42) | (45'd2 << 27), busy: 2445};

        repeat (3) @(negedge CLK);
        chk("reset command", command, NOP);
        chk("reset busy", busy, 0);
        chk("reset frame_done", frame_done, 0);
        chk("reset overrun", overrun, 0);
        reset = 1'b1;
        repeat (2) @(negedge CLK);

        for (int v = 0; v < 5; v++)
            run_frame(vecs[v].sv, vecs[v].sc, vecs[v].busy, 0, 0, $sformatf("vec%0d", v));

        run_frame(vecs[1].sv, vecs[1].sc, vecs[1].busy, 1, 0, "latched inputs");
        run_frame(vecs[2].sv, vecs[2].sc, vecs[2].busy, 0, 1, "overrun inject");

        @(negedge CLK);
        slot_valid  = '0;
        slot_colour = '0;
        frame_tick  = 1'b1;
        @(negedge CLK);
        bad_b = 0; bad_o = 0; bad_d = 0;
        for (int c = 0; c <= 4700; c++) begin
            if (busy !== ((c % 2351) != 2350)) bad_b++;
            if (overrun !== (c > 0 && ((c - 1) % 2351) != 2350)) bad_o++;
            if (frame_done !== ((c % 2351) == 2349)) bad_d++;
            if (c == 2350) chk("b2b gap command", command, NOP);
            if (c == 2351) chk("b2b restart command", command, ERASE);
            if (c == 4700) frame_tick = 1'b0;
            @(negedge CLK);
        end
        chk("b2b busy pattern errors", bad_b, 0);
        chk("b2b overrun pattern errors", bad_o, 0);
        chk("b2b frame_done pattern errors", bad_d, 0);
        chk("b2b final busy", busy, 0);

        @(negedge CLK);
        frame_tick = 1'b1;
        @(negedge CLK);
        frame_tick = 1'b0;
        repeat (100) @(negedge CLK);
        chk("pre-reset erase", command, ERASE);
        #3 reset = 1'b0;
        #1;
        chk("async reset command", command, NOP);
        chk("async reset busy", busy, 0);
        @(negedge CLK);
        reset = 1'b1;
        run_frame(15'h0000, 45'd0, 2350, 0, 0, "after reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
